// File: rtl/trace_pkg.sv
// trace_pkg: shared types and helpers for the retirement trace monitor.
package trace_pkg;
    localparam int TRC_DATA_W = 16;
    localparam int TRC_ADDR_W = 16;
    localparam int TRC_CNT_W  = 32;

    typedef enum logic [1:0] {REG = 2'd0, LOAD = 2'd1, STORE = 2'd2} trace_kind_e;

    typedef struct packed {
        trace_kind_e             kind;
        logic [TRC_ADDR_W-1:0]   tag;
        logic [TRC_DATA_W-1:0]   data;
        logic [TRC_CNT_W-1:0]    cycle;
    } trace_rec_t;

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} mon_state_e;

    function automatic logic [TRC_CNT_W-1:0] sat_add(input logic [TRC_CNT_W-1:0] a, input logic [1:0] b);
        logic [TRC_CNT_W:0] s;
        s = {1'b0, a} + {{(TRC_CNT_W-1){1'b0}}, b};
        return s[TRC_CNT_W] ? '1 : s[TRC_CNT_W-1:0];
    endfunction
endpackage

// File: rtl/retire_trace_monitor_if.sv
// retire_trace_monitor_if: valid/ready trace record stream.
interface retire_trace_monitor_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 32
);
    logic              trc_valid;
    logic              trc_ready;
    logic [1:0]        trc_kind;
    logic [ADDR_W-1:0] trc_tag;
    logic [DATA_W-1:0] trc_data;
    logic [CNT_W-1:0]  trc_cycle;

    modport master (output trc_valid, trc_kind, trc_tag, trc_data, trc_cycle, input trc_ready);
    modport slave  (input trc_valid, trc_kind, trc_tag, trc_data, trc_cycle, output trc_ready);
endinterface

// File: rtl/trace_fifo_2w1r.sv
// trace_fifo_2w1r: record FIFO accepting 0-2 ordered pushes and one pop per cycle.
module trace_fifo_2w1r
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               push_n_i,
    input  trace_rec_t               wdata0_i,
    input  trace_rec_t               wdata1_i,
    input  logic                     pop_i,
    output trace_rec_t               rdata_o,
    output logic [$clog2(DEPTH):0]   occ_o
);
    localparam int PW = $clog2(DEPTH);

    trace_rec_t     mem_q [DEPTH];
    logic [PW-1:0]  wr_q, rd_q;
    logic [PW:0]    occ_q;
    logic           do_pop;

    assign do_pop  = pop_i && occ_q != '0;
    assign rdata_o = mem_q[rd_q];
    assign occ_o   = occ_q;

    // The caller never pushes more than the free slots, so no full check here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_n_i != 2'd0) mem_q[wr_q] <= wdata0_i;
            if (push_n_i == 2'd2) mem_q[wr_q + PW'(1)] <= wdata1_i;
            wr_q  <= wr_q + PW'(push_n_i);
            rd_q  <= rd_q + PW'(do_pop);
            occ_q <= occ_q + (PW+1)'(push_n_i) - (PW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/retire_trace_monitor.sv
// retire_trace_monitor: packs retirement events into timestamped trace records,
// keeps saturating statistics and a cycle-limit watchdog.
module retire_trace_monitor
    import trace_pkg::*;
#(
    parameter int DATA_W     = TRC_DATA_W,
    parameter int ADDR_W     = TRC_ADDR_W,
    parameter int REG_W      = 4,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = TRC_CNT_W,
    parameter int MAX_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wb_regwrite,
    input  logic [REG_W-1:0]    wb_reg,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                halt,
    retire_trace_monitor_if.master trc,
    output logic [CNT_W-1:0]    cycle_count,
    output logic [CNT_W-1:0]    inst_count,
    output logic [CNT_W-1:0]    drop_count,
    output logic                overflow,
    output logic                done,
    output logic                timeout
);
    localparam int OW = $clog2(DEPTH) + 1;

    mon_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cycle_q, inst_q, drop_q;
    logic              overflow_q, timeout_q;
    logic [OW-1:0]     occ, free;
    logic              run, wd_hit, mem_ev;
    logic [1:0]        n_ev, n_push, n_drop;
    trace_rec_t        reg_rec, mem_rec, rec0, rdata;

    assign run     = state_q == RUN;
    assign wd_hit  = run && cycle_q == CNT_W'(MAX_CYCLES - 1);
    assign mem_ev  = mem_read | mem_write;
    assign reg_rec = '{kind: REG, tag: ADDR_W'(wb_reg), data: wb_data, cycle: cycle_q};
    assign mem_rec = '{kind: mem_write ? STORE : LOAD, tag: mem_addr,
                       data: mem_write ? mem_wdata : mem_rdata, cycle: cycle_q};
    assign rec0    = wb_regwrite ? reg_rec : mem_rec;
    assign n_ev    = run ? {1'b0, wb_regwrite} + {1'b0, mem_ev} : 2'd0;
    // A pop in this cycle does not free a slot for this cycle's events.
    assign free    = OW'(DEPTH) - occ;
    assign n_push  = free >= OW'(n_ev) ? n_ev : free[1:0];
    assign n_drop  = n_ev - n_push;

    trace_fifo_2w1r #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_n_i (n_push),
        .wdata0_i (rec0),
        .wdata1_i (mem_rec),
        .pop_i    (trc.trc_valid & trc.trc_ready),
        .rdata_o  (rdata),
        .occ_o    (occ)
    );

    always_comb begin
        state_d = state_q;
        if (run && (halt || wd_hit)) state_d = DRAIN;
        else if (state_q == DRAIN && occ == '0) state_d = DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            cycle_q    <= '0;
            inst_q     <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (run) begin
                cycle_q    <= sat_add(cycle_q, 2'd1);
                inst_q     <= sat_add(inst_q, {1'b0, halt | wb_regwrite | mem_write});
                drop_q     <= sat_add(drop_q, n_drop);
                overflow_q <= overflow_q | (n_drop != 2'd0);
                timeout_q  <= timeout_q | wd_hit;
            end
        end
    end

    assign trc.trc_valid = occ != '0;
    assign trc.trc_kind  = rdata.kind;
    assign trc.trc_tag   = rdata.tag;
    assign trc.trc_data  = rdata.data;
    assign trc.trc_cycle = rdata.cycle;
    assign cycle_count   = cycle_q;
    assign inst_count    = inst_q;
    assign drop_count    = drop_q;
    assign overflow      = overflow_q;
    assign timeout       = timeout_q;
    assign done          = state_q == DONE;
endmodule

// File: tb/tb_retire_trace_monitor.sv
// tb_retire_trace_monitor: randomized scoreboard bench against a queue-based reference model.
module tb_retire_trace_monitor;
    localparam int DEPTH = 8;
    localparam int MAXC  = 300;
    localparam longint CMAX = 64'hFFFF_FFFF;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        wb_regwrite, mem_read, mem_write, halt;
    logic [3:0]  wb_reg;
    logic [15:0] wb_data, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] cycle_count, inst_count, drop_count;
    logic        overflow, done, timeout;

    retire_trace_monitor_if #(.ADDR_W(16), .DATA_W(16), .CNT_W(32)) trc ();

    retire_trace_monitor #(.DATA_W(16), .ADDR_W(16), .REG_W(4), .DEPTH(DEPTH), .CNT_W(32), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .rst_n(rst_n), .wb_regwrite(wb_regwrite), .wb_reg(wb_reg), .wb_data(wb_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .halt(halt), .trc(trc), .cycle_count(cycle_count),
        .inst_count(inst_count), .drop_count(drop_count), .overflow(overflow), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a list of records that should sit in the FIFO, plus plain counters.
    typedef struct { bit [1:0] kind; bit [15:0] tag; bit [15:0] data; bit [31:0] cyc; } rec_t;
    rec_t   exp_q[$];
    rec_t   ev[$];
    int     m_occ, m_phase, m_free, m_dropped, m_pop;
    longint m_cyc, m_inst, m_drop;
    bit     m_ovf, m_to;

    function automatic longint sat(input longint v);
        return v > CMAX ? CMAX : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_occ = 0; m_phase = 0; m_cyc = 0; m_inst = 0; m_drop = 0; m_ovf = 0; m_to = 0;
        end else begin
            m_pop = (m_occ > 0 && trc.trc_ready) ? 1 : 0;
            if (m_phase == 0) begin
                ev.delete();
                if (wb_regwrite) ev.push_back('{2'd0, {12'd0, wb_reg}, wb_data, m_cyc[31:0]});
                if (mem_read)    ev.push_back('{2'd1, mem_addr, mem_rdata, m_cyc[31:0]});
                if (mem_write)   ev.push_back('{2'd2, mem_addr, mem_wdata, m_cyc[31:0]});
                m_free = DEPTH - m_occ;
                m_dropped = 0;
                foreach (ev[i]) begin
                    if (m_free > 0) begin exp_q.push_back(ev[i]); m_free--; m_occ++; end
                    else m_dropped++;
                end
                m_drop = sat(m_drop + m_dropped);
                if (m_dropped > 0) m_ovf = 1;
                if (halt || wb_regwrite || mem_write) m_inst = sat(m_inst + 1);
                if (m_cyc == MAXC - 1) begin m_to = 1; m_phase = 1; end
                if (halt) m_phase = 1;
                m_cyc = sat(m_cyc + 1);
            end else if (m_phase == 1 && m_occ == 0) begin
                m_phase = 2;
            end
            m_occ -= m_pop;
        end
    end

    // Monitor: compares the head record and statistics away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("trc_valid", trc.trc_valid, exp_q.size() > 0);
            if (exp_q.size() > 0 && trc.trc_valid) begin
                chk("rec_kind", trc.trc_kind, exp_q[0].kind);
                chk("rec_tag", trc.trc_tag, exp_q[0].tag);
                chk("rec_data", trc.trc_data, exp_q[0].data);
                chk("rec_cycle", trc.trc_cycle, exp_q[0].cyc);
                if (trc.trc_ready) void'(exp_q.pop_front());
            end
            chk("cycle_count", cycle_count, m_cyc);
            chk("inst_count", inst_count, m_inst);
            chk("drop_count", drop_count, m_drop);
            chk("overflow", overflow, m_ovf);
            chk("timeout", timeout, m_to);
            chk("done", done, m_phase == 2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        wb_regwrite = 0; mem_read = 0; mem_write = 0; halt = 0;
    endtask

    task automatic rnd_ev(input int p_reg, input int p_rd, input int p_wr);
        int r;
        wb_regwrite = $urandom_range(99) < p_reg;
        wb_reg = 4'($urandom); wb_data = 16'($urandom);
        mem_addr = 16'($urandom); mem_wdata = 16'($urandom); mem_rdata = 16'($urandom);
        r = $urandom_range(99);
        mem_read  = r < p_rd;
        mem_write = !mem_read && r < p_rd + p_wr;
        halt = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, trc.trc_valid, 0);
        chk({tag, "_kind"}, trc.trc_kind, 0);
        chk({tag, "_tag"}, trc.trc_tag, 0);
        chk({tag, "_data"}, trc.trc_data, 0);
        chk({tag, "_tcycle"}, trc.trc_cycle, 0);
        chk({tag, "_cycles"}, cycle_count, 0);
        chk({tag, "_insts"}, inst_count, 0);
        chk({tag, "_drops"}, drop_count, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_to"}, timeout, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        idle();
        wb_reg = 0; wb_data = 0; mem_addr = 0; mem_wdata = 0; mem_rdata = 0;
        trc.trc_ready = 0;
        #12;
        check_zero("reset");
        rst_n = 1;
        tick();
        trc.trc_ready = 1;
        repeat (3) tick();
        // single register write
        wb_regwrite = 1; wb_reg = 4'd3; wb_data = 16'h1234;
        tick();
        idle();
        repeat (3) tick();
        chk("single_inst", inst_count, 1);
        // register write and store in one cycle
        wb_regwrite = 1; wb_reg = 4'd2; wb_data = 16'hAAAA;
        mem_write = 1; mem_addr = 16'h0040; mem_wdata = 16'h5555;
        tick();
        idle();
        repeat (4) tick();
        chk("dual_inst", inst_count, 2);
        // overflow with sink stalled
        trc.trc_ready = 0;
        repeat (5) begin
            rnd_ev(100, 0, 0); wb_regwrite = 1; mem_write = 1;
            tick();
        end
        idle();
        tick();
        chk("ovf_drops", drop_count, 2);
        chk("ovf_flag", overflow, 1);
        chk("ovf_full", trc.trc_valid, 1);
        trc.trc_ready = 1;
        repeat (12) tick();
        // load burst with random backpressure
        repeat (60) begin
            rnd_ev(20, 100, 0);
            trc.trc_ready = $urandom_range(1);
            tick();
        end
        idle(); trc.trc_ready = 1;
        repeat (12) tick();
        // random mix
        repeat (60) begin
            rnd_ev(50, 30, 30);
            trc.trc_ready = $urandom_range(3) != 0;
            tick();
        end
        idle(); trc.trc_ready = 1;
        repeat (12) tick();
        // halt with three records queued
        trc.trc_ready = 0;
        rnd_ev(100, 100, 0);
        tick();
        rnd_ev(100, 0, 0); halt = 1;
        tick();
        repeat (3) begin rnd_ev(80, 40, 40); tick(); end
        chk("halt_done_low", done, 0);
        chk("halt_held", trc.trc_valid, 1);
        idle(); trc.trc_ready = 1;
        for (int i = 0; i < 30 && !done; i++) tick();
        chk("halt_done", done, 1);
        chk("halt_no_to", timeout, 0);
        // restart, then let the watchdog expire
        #1 rst_n = 0;
        #1 check_zero("rst1");
        tick();
        rst_n = 1;
        tick();
        for (int i = 0; i < MAXC + 10 && !timeout; i++) begin
            rnd_ev(60, 30, 30);
            if (cycle_count >= MAXC - 10) begin wb_regwrite = 1; trc.trc_ready = 0; end
            else trc.trc_ready = $urandom_range(1);
            tick();
        end
        chk("wd_timeout", timeout, 1);
        chk("wd_cycles", cycle_count, MAXC);
        rnd_ev(60, 30, 30);
        tick();
        chk("wd_draining", done, 0);
        #1 rst_n = 0;
        #1 check_zero("rst2");
        tick();
        rst_n = 1;
        trc.trc_ready = 1;
        repeat (20) begin rnd_ev(50, 30, 30); tick(); end
        chk("restart_run", cycle_count, 20);
        idle();
        repeat (10) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
